conv_result_writer: RTL



---
 rtl/conv_result_writer_pkg.sv | 24 ++
 rtl/conv_result_writer_sync_fifo.sv | 48 ++++
 rtl/conv_result_writer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/conv_result_writer_pkg.sv
// Shared geometry, state type and requantization helper for the convolution result writer.
package conv_result_writer_pkg;

  localparam int unsigned DATA_W    = 36;
  localparam int unsigned PIX_W     = 9;
  localparam int unsigned OUT_W     = 224;
  localparam int unsigned OUT_H     = 224;
  localparam int unsigned FRAME_PIX = OUT_W * OUT_H;

  localparam logic signed [DATA_W-1:0] PIX_MAX = DATA_W'((1 << PIX_W) - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  // Arithmetic right shift (floor), then clamp into the unsigned pixel range.
  function automatic logic [PIX_W-1:0] sat_quant(input logic signed [DATA_W-1:0] value,
                                                 input int unsigned shift);
    logic signed [DATA_W-1:0] q;
    q = value >>> shift;
    if (q[DATA_W-1] || q == '0) return '0;
    if (q >= PIX_MAX) return '1;
    return q[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/conv_result_writer_sync_fifo.sv
// Small synchronous FIFO; a push while full is accepted only when a pop happens in the same cycle.
module conv_result_writer_sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[PTR_W-1:0]] <= din;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_result_writer.sv
// Requantizes the convolution result stream and writes it to feature-map memory through a
// skid FIFO that absorbs memory backpressure; reports drops and frame completion.
module conv_result_writer
  import conv_result_writer_pkg::*;
#(
  parameter int unsigned OUT_W      = conv_result_writer_pkg::OUT_W,
  parameter int unsigned OUT_H      = conv_result_writer_pkg::OUT_H,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned SHIFT      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [PIX_W-1:0]         mem_wdata,
  output logic                     mem_we,
  input  logic                     mem_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  localparam int unsigned      FRAME_N   = OUT_W * OUT_H;
  localparam int unsigned      CNT_W     = $clog2(FRAME_N + 1);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_N);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  acc_cnt_q;
  logic [CNT_W-1:0]  ret_cnt_q, ret_cnt_d;
  logic              overflow_q;
  logic [ADDR_W-1:0] addr_q;
  logic [PIX_W-1:0]  wdata_q;
  logic              we_q;

  logic             start_ok, accept, load, pop, push, drop, wr_done;
  logic             fifo_full, fifo_empty;
  logic [PIX_W-1:0] fifo_dout, pix;

  assign pix      = sat_quant(in_data, SHIFT);
  assign start_ok = start && (state_q == StIdle || state_q == StDone);
  assign accept   = (state_q == StRun) && in_valid && (acc_cnt_q < FRAME_CNT);
  assign wr_done  = we_q && mem_ready;
  assign load     = !we_q || mem_ready;
  assign pop      = load && !fifo_empty;
  assign push     = accept && (!fifo_full || pop);
  assign drop     = accept && fifo_full && !pop;

  // Dropped results are retired too, so a lossy frame still reaches DONE.
  assign ret_cnt_d = ret_cnt_q + CNT_W'(wr_done) + CNT_W'(drop);

  conv_result_writer_sync_fifo #(
    .WIDTH(PIX_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (pix),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StRun;
      StRun:          if (acc_cnt_q == FRAME_CNT) state_d = StDrain;
      StDrain:        if (ret_cnt_d == FRAME_CNT) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StRun) || (state_q == StDrain);
    done = (state_q == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cnt_q  <= '0;
      ret_cnt_q  <= '0;
      overflow_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
    end else begin
      if (start_ok) begin
        acc_cnt_q  <= '0;
        ret_cnt_q  <= '0;
        addr_q     <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (accept) acc_cnt_q <= acc_cnt_q + 1'b1;
        if (drop) overflow_q <= 1'b1;
        if (wr_done) addr_q <= addr_q + 1'b1;
        ret_cnt_q <= ret_cnt_d;
      end
      if (load) begin
        we_q <= !fifo_empty;
        if (!fifo_empty) wdata_q <= fifo_dout;
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign overflow  = overflow_q;

endmodule
